// File: rtl/tag_lookup_pipe_if.sv
// Lookup, response, fill and invalidate signal bundle for tag_lookup_pipe.
// The master drives requests and array updates; the slave is the tag store.
interface tag_lookup_pipe_if #(
    parameter int WAYS       = 8,
    parameter int TAG_BITS   = 10,
    parameter int INDEX_BITS = 4
);
    localparam int WAY_BITS = $clog2(WAYS);

    logic                  reqValid;
    logic                  reqReady;
    logic [INDEX_BITS-1:0] reqIndex;
    logic [TAG_BITS-1:0]   reqTag;

    logic                  respValid;
    logic                  respReady;
    logic                  respHit;
    logic [WAY_BITS-1:0]   respWay;
    logic                  respMultiHit;
    logic [WAY_BITS-1:0]   respVictim;

    logic                  fillValid;
    logic [INDEX_BITS-1:0] fillIndex;
    logic [WAY_BITS-1:0]   fillWay;
    logic [TAG_BITS-1:0]   fillTag;

    logic                  invValid;
    logic [INDEX_BITS-1:0] invIndex;
    logic [WAY_BITS-1:0]   invWay;

    modport master (
        output reqValid, reqIndex, reqTag, respReady,
        output fillValid, fillIndex, fillWay, fillTag,
        output invValid, invIndex, invWay,
        input  reqReady, respValid, respHit, respWay,
        input  respMultiHit, respVictim
    );

    modport slave (
        input  reqValid, reqIndex, reqTag, respReady,
        input  fillValid, fillIndex, fillWay, fillTag,
        input  invValid, invIndex, invWay,
        output reqReady, respValid, respHit, respWay,
        output respMultiHit, respVictim
    );
endinterface

// File: rtl/tag_lookup_pipe.sv
// N-way set-associative tag/valid store with a two-stage lookup pipeline.
// Returns hit, lowest hit way, multi-hit error and a replacement victim.
module tag_lookup_pipe #(
    parameter int WAYS       = 8,
    parameter int TAG_BITS   = 10,
    parameter int INDEX_BITS = 4
) (
    input logic clk,
    input logic reset,
    tag_lookup_pipe_if.slave bus
);
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int SETS     = 1 << INDEX_BITS;

    logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAY_BITS-1:0] rrPtr_q [SETS];

    logic                  s1Valid_q, s1Valid_d;
    logic [INDEX_BITS-1:0] s1Index_q, s1Index_d;
    logic [TAG_BITS-1:0]   s1Tag_q, s1Tag_d;

    logic                respValid_q, respValid_d;
    logic                respHit_q, respHit_d;
    logic [WAY_BITS-1:0] respWay_q, respWay_d;
    logic                respMulti_q, respMulti_d;
    logic [WAY_BITS-1:0] respVictim_q, respVictim_d;

    logic                advance;
    logic                reqReady;
    logic                accept;
    logic [WAYS-1:0]     setValid;
    logic [WAYS-1:0]     match;
    logic                cmpHit;
    logic [WAY_BITS-1:0] cmpWay;
    logic                cmpMulti;
    logic [WAY_BITS-1:0] cmpVictim;

    assign advance  = !respValid_q || bus.respReady;
    assign reqReady = advance || !s1Valid_q;
    assign accept   = bus.reqValid && reqReady;

    // Tags carry no reset; validity alone decides whether a way counts.
    always_ff @(posedge clk) begin
        if (bus.fillValid) begin
            tag_q[bus.fillIndex][bus.fillWay] <= bus.fillTag;
        end
    end

    // Invalidate is applied after fill so a same-slot collision ends invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rrPtr_q[s] <= '0;
            end
        end else begin
            if (bus.fillValid) begin
                valid_q[bus.fillIndex][bus.fillWay] <= 1'b1;
                rrPtr_q[bus.fillIndex] <=
                    rrPtr_q[bus.fillIndex] + WAY_BITS'(1);
            end
            if (bus.invValid) begin
                valid_q[bus.invIndex][bus.invWay] <= 1'b0;
            end
        end
    end

    always_comb begin
        setValid = valid_q[s1Index_q];
        match    = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = setValid[w] &&
                       (tag_q[s1Index_q][w] == s1Tag_q);
        end
        cmpHit   = |match;
        cmpMulti = (match & (match - WAYS'(1))) != '0;
        cmpWay   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) begin
                cmpWay = WAY_BITS'(w);
            end
        end
        // Prefer an empty way; fall back to the set's round-robin pointer.
        cmpVictim = rrPtr_q[s1Index_q];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!setValid[w]) begin
                cmpVictim = WAY_BITS'(w);
            end
        end
    end

    always_comb begin
        s1Valid_d = s1Valid_q;
        s1Index_d = s1Index_q;
        s1Tag_d   = s1Tag_q;
        if (accept) begin
            s1Valid_d = 1'b1;
            s1Index_d = bus.reqIndex;
            s1Tag_d   = bus.reqTag;
        end else if (advance) begin
            s1Valid_d = 1'b0;
        end
    end

    always_comb begin
        respValid_d  = respValid_q;
        respHit_d    = respHit_q;
        respWay_d    = respWay_q;
        respMulti_d  = respMulti_q;
        respVictim_d = respVictim_q;
        if (advance) begin
            respValid_d = s1Valid_q;
            if (s1Valid_q) begin
                respHit_d    = cmpHit;
                respWay_d    = cmpWay;
                respMulti_d  = cmpMulti;
                respVictim_d = cmpVictim;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid_q    <= 1'b0;
            s1Index_q    <= '0;
            s1Tag_q      <= '0;
            respValid_q  <= 1'b0;
            respHit_q    <= 1'b0;
            respWay_q    <= '0;
            respMulti_q  <= 1'b0;
            respVictim_q <= '0;
        end else begin
            s1Valid_q    <= s1Valid_d;
            s1Index_q    <= s1Index_d;
            s1Tag_q      <= s1Tag_d;
            respValid_q  <= respValid_d;
            respHit_q    <= respHit_d;
            respWay_q    <= respWay_d;
            respMulti_q  <= respMulti_d;
            respVictim_q <= respVictim_d;
        end
    end

    assign bus.reqReady     = reqReady;
    assign bus.respValid    = respValid_q;
    assign bus.respHit      = respHit_q;
    assign bus.respWay      = respWay_q;
    assign bus.respMultiHit = respMulti_q;
    assign bus.respVictim   = respVictim_q;
endmodule

// File: tb/tb_tag_lookup_pipe.sv
// Directed bench for tag_lookup_pipe: lookups, fills, invalidates,
// stall/backpressure and asynchronous reset with hand-computed results.
module tb_tag_lookup_pipe;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    tag_lookup_pipe_if #(.WAYS(8), .TAG_BITS(10), .INDEX_BITS(4)) bus ();

    tag_lookup_pipe #(.WAYS(8), .TAG_BITS(10), .INDEX_BITS(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    endtask

    task automatic resp(input string nm, input logic eh,
                        input logic [2:0] ew, input logic em,
                        input logic [2:0] ev);
        check({nm, ".valid"}, bus.respValid, 1);
        check({nm, ".hit"}, bus.respHit, eh);
        check({nm, ".way"}, bus.respWay, ew);
        check({nm, ".multi"}, bus.respMultiHit, em);
        check({nm, ".victim"}, bus.respVictim, ev);
    endtask

    task automatic lookup(input string nm, input logic [3:0] idx,
                          input logic [9:0] tg, input logic eh,
                          input logic [2:0] ew, input logic em,
                          input logic [2:0] ev);
        bus.reqValid = 1'b1;
        bus.reqIndex = idx;
        bus.reqTag   = tg;
        check({nm, ".rdy"}, bus.reqReady, 1);
        tick();
        bus.reqValid = 1'b0;
        check({nm, ".lat"}, bus.respValid, 0);
        tick();
        resp(nm, eh, ew, em, ev);
    endtask

    task automatic wr(input logic fv, input logic [3:0] fi,
                      input logic [2:0] fw, input logic [9:0] ft,
                      input logic iv, input logic [3:0] ii,
                      input logic [2:0] iw);
        bus.fillValid = fv;
        bus.fillIndex = fi;
        bus.fillWay   = fw;
        bus.fillTag   = ft;
        bus.invValid  = iv;
        bus.invIndex  = ii;
        bus.invWay    = iw;
        tick();
        bus.fillValid = 1'b0;
        bus.invValid  = 1'b0;
    endtask

    task automatic fill(input logic [3:0] fi, input logic [2:0] fw,
                        input logic [9:0] ft);
        wr(1'b1, fi, fw, ft, 1'b0, 4'd0, 3'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.reqValid  = 1'b0;
        bus.reqIndex  = '0;
        bus.reqTag    = '0;
        bus.respReady = 1'b1;
        bus.fillValid = 1'b0;
        bus.fillIndex = '0;
        bus.fillWay   = '0;
        bus.fillTag   = '0;
        bus.invValid  = 1'b0;
        bus.invIndex  = '0;
        bus.invWay    = '0;
        #12;
        check("rst.valid", bus.respValid, 0);
        check("rst.hit", bus.respHit, 0);
        check("rst.way", bus.respWay, 0);
        check("rst.victim", bus.respVictim, 0);
        reset = 1'b0;
        tick();

        lookup("t1", 4'd3, 10'h155, 0, 3'd0, 0, 3'd0);

        fill(4'd3, 3'd5, 10'h155);
        lookup("t2", 4'd3, 10'h155, 1, 3'd5, 0, 3'd0);

        for (int w = 0; w < 8; w++) fill(4'd2, 3'(w), 10'h200 + 10'(w));
        fill(4'd2, 3'd4, 10'h204);
        lookup("t3miss", 4'd2, 10'h3FF, 0, 3'd0, 0, 3'd1);
        lookup("t3hit", 4'd2, 10'h203, 1, 3'd3, 0, 3'd1);
        for (int w = 0; w < 7; w++) fill(4'd2, 3'(w), 10'h200 + 10'(w));
        lookup("t3wrap", 4'd2, 10'h3FF, 0, 3'd0, 0, 3'd0);

        fill(4'd7, 3'd1, 10'h0AA);
        fill(4'd7, 3'd6, 10'h0AA);
        lookup("t4multi", 4'd7, 10'h0AA, 1, 3'd1, 1, 3'd0);
        wr(1'b0, 4'd0, 3'd0, 10'h0, 1'b1, 4'd7, 3'd1);
        lookup("t4inv", 4'd7, 10'h0AA, 1, 3'd6, 0, 3'd0);

        // Fill and invalidate of one slot: ends invalid, pointer still moves.
        wr(1'b1, 4'd9, 3'd2, 10'h302, 1'b1, 4'd9, 3'd2);
        lookup("coll", 4'd9, 10'h302, 0, 3'd0, 0, 3'd0);
        for (int w = 0; w < 8; w++)
            if (w != 2) fill(4'd9, 3'(w), 10'h300 + 10'(w));
        lookup("coll7", 4'd9, 10'h3FF, 0, 3'd0, 0, 3'd2);
        fill(4'd9, 3'd2, 10'h302);
        lookup("collrr", 4'd9, 10'h3FF, 0, 3'd0, 0, 3'd1);
        wr(1'b1, 4'd11, 3'd0, 10'h0B0, 1'b1, 4'd9, 3'd3);
        lookup("both9", 4'd9, 10'h303, 0, 3'd0, 0, 3'd3);
        lookup("both11", 4'd11, 10'h0B0, 1, 3'd0, 0, 3'd1);

        // A fill on the compare edge is not seen; the next compare sees it.
        bus.reqValid = 1'b1;
        bus.reqIndex = 4'd10;
        bus.reqTag   = 10'h0F0;
        tick();
        bus.reqValid = 1'b0;
        wr(1'b1, 4'd10, 3'd0, 10'h0F0, 1'b0, 4'd0, 3'd0);
        resp("nobyp", 0, 3'd0, 0, 3'd0);
        lookup("byp", 4'd10, 10'h0F0, 1, 3'd0, 0, 3'd1);

        fill(4'd5, 3'd0, 10'h050);
        bus.respReady = 1'b0;
        bus.reqValid  = 1'b1;
        bus.reqIndex  = 4'd5;
        bus.reqTag    = 10'h050;
        tick();
        check("stA.lat", bus.respValid, 0);
        bus.reqTag = 10'h051;
        tick();
        resp("stA", 1, 3'd0, 0, 3'd1);
        check("stA.rdy", bus.reqReady, 0);
        bus.reqTag = 10'h052;
        wr(1'b1, 4'd5, 3'd1, 10'h051, 1'b0, 4'd0, 3'd0);
        for (int k = 0; k < 3; k++) begin
            resp($sformatf("hold%0d", k), 1, 3'd0, 0, 3'd1);
            check($sformatf("hold%0d.rdy", k), bus.reqReady, 0);
            if (k < 2) tick();
        end
        bus.respReady = 1'b1;
        #1;
        check("rel.rdy", bus.reqReady, 1);
        tick();
        bus.reqValid = 1'b0;
        resp("stB", 1, 3'd1, 0, 3'd2);
        tick();
        resp("stC", 0, 3'd0, 0, 3'd2);
        tick();
        check("st.drain", bus.respValid, 0);

        bus.respReady = 1'b0;
        bus.reqValid  = 1'b1;
        bus.reqIndex  = 4'd3;
        bus.reqTag    = 10'h155;
        tick();
        tick();
        bus.reqValid = 1'b0;
        resp("pre", 1, 3'd5, 0, 3'd0);
        check("pre.rdy", bus.reqReady, 0);
        #2 reset = 1'b1;
        #1;
        check("arst.valid", bus.respValid, 0);
        check("arst.hit", bus.respHit, 0);
        check("arst.way", bus.respWay, 0);
        check("arst.victim", bus.respVictim, 0);
        check("arst.rdy", bus.reqReady, 1);
        tick();
        reset         = 1'b0;
        bus.respReady = 1'b1;
        tick();
        check("post.idle", bus.respValid, 0);
        lookup("post3", 4'd3, 10'h155, 0, 3'd0, 0, 3'd0);
        lookup("post2", 4'd2, 10'h203, 0, 3'd0, 0, 3'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tag_lookup_pipe.md
Name: tag_lookup_pipe

Overview:
- Parametrised, pipelined successor to the combinational hit detector.
- Owns the per-set tag/valid arrays for an N-way set-associative L2, accepts lookup requests over a valid/ready handshake, and returns hit, hit-way, multi-hit error and a replacement victim two cycles later.
- Fill and invalidate ports update the arrays; sits between the L2 request decoder and the data-array/controller FSM.

Parameters:
WAYS, 8, associativity; power of two, >=2; WAY_BITS = clog2(WAYS) is derived locally
TAG_BITS, 10, tag width
INDEX_BITS, 4, set index width; SETS = 2**INDEX_BITS

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
reqValid  in  1  lookup request present
reqReady  out  1  lookup accepted when reqValid && reqReady
reqIndex  in  INDEX_BITS  lookup set
reqTag  in  TAG_BITS  lookup tag
respValid  out  1  response present
respReady  in  1  consumer accepts response
respHit  out  1  some valid way matched
respWay  out  WAY_BITS  lowest matching way; 0 on miss
respMultiHit  out  1  more than one valid way matched (protocol error)
respVictim  out  WAY_BITS  replacement way for the looked-up set
fillValid  in  1  write tag and set valid
fillIndex  in  INDEX_BITS  fill set
fillWay  in  WAY_BITS  fill way
fillTag  in  TAG_BITS  fill tag
invValid  in  1  clear valid bit
invIndex  in  INDEX_BITS  invalidate set
invWay  in  WAY_BITS  invalidate way

Behaviour:
- Storage: tag[SETS][WAYS] (not reset), valid[SETS][WAYS] (reset 0), rrPtr[SETS] of WAY_BITS bits (reset 0).
- Reset (async, any time): valid bits cleared, rrPtr cleared, S1 valid cleared, respValid=0, respHit=0, respWay=0, respMultiHit=0, respVictim=0. In-flight requests are dropped, not replayed.
- Pipeline:
  - S1 register (s1Valid, s1Index, s1Tag) followed by the output register.
  - advance = !respValid || respReady.
  - reqReady = advance || !s1Valid. A request is accepted into S1 on reqValid && reqReady.
  - When advance && s1Valid: compare s1Tag against all WAYS of s1Index using array contents in that cycle; register the results into the outputs and set respValid=1.
  - When advance && !s1Valid: respValid=0.
  - Latency: accepted at edge N gives respValid high after edge N+1 (response visible in cycle N+1, i.e. two cycles from request presentation). Full throughput of 1 lookup/cycle with respReady held high.
- Stall: while respValid && !respReady, all resp* outputs are held stable and S1 is held. S1 is re-compared only when it advances, so it sees any fill/invalidate made during the stall.
- Compare: match[w] = valid[s1Index][w] && (tag[s1Index][w] == s1Tag).
  - respHit = OR of match[w].
  - respWay = lowest w with match[w] set.
  - respMultiHit = popcount(match) > 1.
- Victim: the lowest-index invalid way of the set if one exists, else rrPtr[s1Index]. Driven on hits too.
- Fill: at the edge, tag[fillIndex][fillWay] <= fillTag, valid <= 1, and rrPtr[fillIndex] <= rrPtr[fillIndex] + 1, wrapping WAYS-1 -> 0.
- Invalidate: at the edge, valid[invIndex][invWay] <= 0. The tag and rrPtr are unchanged.
- Fill and invalidate on the same index/way in the same cycle: the tag is written, valid ends 0, and rrPtr still advances. On different locations both apply.
- Write-vs-compare ordering: a write at edge E is not visible to a compare performed in the cycle before E. It is visible to every compare from the cycle after E. There is no bypass.

Test Plan:
1. Reset, then lookup idx=3 tag=0x155 -> respValid after 2 cycles; respHit=0, respWay=0, respVictim=0, respMultiHit=0.
2. Fill idx=3 way=5 tag=0x155, then lookup idx=3 tag=0x155 -> respHit=1, respWay=5; respVictim=0 (way 0 still invalid).
3. Fill all 8 ways of idx=2 (rrPtr wraps to 0), fill way 4 again, then miss lookup idx=2 -> respHit=0, respVictim=1; a further 7 fills -> respVictim=0 (wrap check).
4. Fill ways 1 and 6 of idx=7 with tag 0x0AA, then lookup -> respHit=1, respWay=1, respMultiHit=1. Invalidate way 1, then lookup -> respWay=6, respMultiHit=0.
5. Back-to-back lookups with respReady low for 3 cycles -> outputs held constant and reqReady=0 once S1 is full. Release respReady -> responses arrive in request order with none lost or duplicated. A fill during the stall is reflected in the stalled S1 result.
6. Assert reset while respValid=1 and S1 is full -> outputs zero immediately (async), valid arrays cleared, and the next lookup of a previously filled tag misses.
